// File: rtl/ex_branch_resolve.sv
// ex_branch_resolve
//   EX-stage branch resolution on the consumer side of the condition-code
//   path. Classifies the EX instruction, waits for a pending CC update when a
//   conditional branch needs it, issues a registered PC redirect and then
//   holds the IF/ID flush for a fixed window. Saturating counters record
//   resolved and taken conditional branches for performance debug.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   ex_valid             EX holds a valid instruction
//   ex_opcode[3:0]       lc3b opcode of the EX instruction
//   ex_br_nzp[2:0]       nzp mask (IR[11:9]) of the EX instruction
//   ex_target[15:0]      computed target PC of the EX instruction
//   cc[2:0]              architected nzp from the CC tracker
//   cc_pending           older MEM instruction writes CC on the next edge
//   mem_stall            global memory stall, freezes this block
//   br_stall             hold EX (combinational)
//   redirect             registered one-cycle PC redirect strobe
//   redirect_pc[15:0]    registered redirect target
//   flush_if, flush_id   squash the IF / ID instructions
//   resolve_count        conditional branches resolved (saturating)
//   taken_count          conditional branches taken (saturating)

module ex_branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  input  logic [3:0]           ex_opcode,
  input  logic [2:0]           ex_br_nzp,
  input  logic [15:0]          ex_target,
  input  logic [2:0]           cc,
  input  logic                 cc_pending,
  input  logic                 mem_stall,
  output logic                 br_stall,
  output logic                 redirect,
  output logic [15:0]          redirect_pc,
  output logic                 flush_if,
  output logic                 flush_id,
  output logic [CNT_WIDTH-1:0] resolve_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [2:0]           FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CC  = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  state_t                 state_r, next_state_s;
  logic [3:0]             lat_opcode_r;
  logic [2:0]             lat_nzp_r;
  logic [15:0]            lat_target_r;
  logic [2:0]             flush_cnt_r, flush_cnt_next_s;
  logic                   redirect_r;
  logic [15:0]            redirect_pc_r, redirect_pc_next_s;
  logic                   flush_r;
  logic [CNT_WIDTH-1:0]   resolve_cnt_r, taken_cnt_r;

  logic                   is_br_s, is_cond_s, is_uncond_s;
  logic                   ex_taken_s, lat_taken_s;
  logic                   latch_en_s, inc_res_s, inc_tkn_s, br_stall_s;

  // Classify the EX instruction and evaluate the branch condition.
  always_comb begin
    is_br_s     = (ex_opcode == OP_BR);
    is_cond_s   = ex_valid && is_br_s && (ex_br_nzp != 3'b000) && (ex_br_nzp != 3'b111);
    is_uncond_s = ex_valid && ((is_br_s && (ex_br_nzp == 3'b111)) ||
                               (ex_opcode == OP_JMP) || (ex_opcode == OP_JSR) ||
                               (ex_opcode == OP_TRAP));
    ex_taken_s  = |(ex_br_nzp & cc);
    lat_taken_s = (lat_opcode_r == OP_BR) && (|(lat_nzp_r & cc));
  end

  // Next-state, stall and update-enable logic.
  always_comb begin
    next_state_s       = state_r;
    flush_cnt_next_s   = flush_cnt_r;
    redirect_pc_next_s = redirect_pc_r;
    latch_en_s         = 1'b0;
    inc_res_s          = 1'b0;
    inc_tkn_s          = 1'b0;
    br_stall_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (is_cond_s) begin
          if (cc_pending) begin
            latch_en_s   = 1'b1;
            br_stall_s   = 1'b1;
            next_state_s = ST_WAIT_CC;
          end else begin
            inc_res_s = 1'b1;
            if (ex_taken_s) begin
              inc_tkn_s          = 1'b1;
              redirect_pc_next_s = ex_target;
              next_state_s       = ST_REDIRECT;
            end else begin
              next_state_s = ST_IDLE;
            end
          end
        end else if (is_uncond_s) begin
          redirect_pc_next_s = ex_target;
          next_state_s       = ST_REDIRECT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT_CC: begin
        // EX is released in the resolving cycle so the branch moves on and
        // is not seen a second time in IDLE.
        if (cc_pending) begin
          br_stall_s   = 1'b1;
          next_state_s = ST_WAIT_CC;
        end else begin
          inc_res_s = 1'b1;
          if (lat_taken_s) begin
            inc_tkn_s          = 1'b1;
            redirect_pc_next_s = lat_target_r;
            next_state_s       = ST_REDIRECT;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
      end
      ST_REDIRECT: begin
        // The redirect cycle is the first cycle of the flush window.
        if (FLUSH_CYCLES > 1) begin
          flush_cnt_next_s = FLUSH_LOAD;
          next_state_s     = ST_FLUSH;
        end else begin
          flush_cnt_next_s = 3'd0;
          next_state_s     = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        flush_cnt_next_s = flush_cnt_r - 3'd1;
        if (flush_cnt_r <= 3'd1) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_FLUSH;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, latched fields, registered outputs and counters; mem_stall freezes all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      lat_opcode_r  <= 4'd0;
      lat_nzp_r     <= 3'd0;
      lat_target_r  <= 16'd0;
      flush_cnt_r   <= 3'd0;
      redirect_r    <= 1'b0;
      redirect_pc_r <= 16'd0;
      flush_r       <= 1'b0;
      resolve_cnt_r <= {CNT_WIDTH{1'b0}};
      taken_cnt_r   <= {CNT_WIDTH{1'b0}};
    end else if (!mem_stall) begin
      state_r       <= next_state_s;
      flush_cnt_r   <= flush_cnt_next_s;
      redirect_pc_r <= redirect_pc_next_s;
      redirect_r    <= (next_state_s == ST_REDIRECT);
      flush_r       <= (next_state_s == ST_REDIRECT) || (next_state_s == ST_FLUSH);
      if (latch_en_s) begin
        lat_opcode_r <= ex_opcode;
        lat_nzp_r    <= ex_br_nzp;
        lat_target_r <= ex_target;
      end
      if (inc_res_s && (resolve_cnt_r != CNT_MAX)) begin
        resolve_cnt_r <= resolve_cnt_r + CNT_ONE;
      end
      if (inc_tkn_s && (taken_cnt_r != CNT_MAX)) begin
        taken_cnt_r <= taken_cnt_r + CNT_ONE;
      end
    end
  end

  assign br_stall      = br_stall_s;
  assign redirect      = redirect_r;
  assign redirect_pc   = redirect_pc_r;
  assign flush_if      = flush_r;
  assign flush_id      = flush_r;
  assign resolve_count = resolve_cnt_r;
  assign taken_count   = taken_cnt_r;

endmodule

// File: tb/tb_ex_branch_resolve.sv
module tb_ex_branch_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [2:0]  ex_br_nzp;
  logic [15:0] ex_target;
  logic [2:0]  cc;
  logic        cc_pending;
  logic        mem_stall;

  logic        br_stall, redirect, flush_if, flush_id;
  logic [15:0] redirect_pc, resolve_count, taken_count;

  logic        b_br_stall, b_redirect, b_flush_if, b_flush_id;
  logic [15:0] b_redirect_pc;
  logic [2:0]  b_resolve_count, b_taken_count;

  int total = 0;
  int bad   = 0;
  int exp_res = 0;
  int exp_tkn = 0;

  always #5 clk = ~clk;

  ex_branch_resolve #(.FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_br_nzp(ex_br_nzp), .ex_target(ex_target), .cc(cc), .cc_pending(cc_pending),
    .mem_stall(mem_stall), .br_stall(br_stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush_if(flush_if), .flush_id(flush_id),
    .resolve_count(resolve_count), .taken_count(taken_count)
  );

  // Small-counter, single-cycle-flush variant for saturation and FLUSH_CYCLES=1.
  ex_branch_resolve #(.FLUSH_CYCLES(1), .CNT_WIDTH(3)) dut_b (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_br_nzp(ex_br_nzp), .ex_target(ex_target), .cc(cc), .cc_pending(cc_pending),
    .mem_stall(mem_stall), .br_stall(b_br_stall), .redirect(b_redirect),
    .redirect_pc(b_redirect_pc), .flush_if(b_flush_if), .flush_id(b_flush_id),
    .resolve_count(b_resolve_count), .taken_count(b_taken_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_counts(input string name);
    check({name, "_res"}, 32'(resolve_count), 32'(exp_res));
    check({name, "_tkn"}, 32'(taken_count), 32'(exp_tkn));
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] nzp,
                       input logic [15:0] tgt, input logic [2:0] c, input logic p);
    ex_valid   = v;
    ex_opcode  = op;
    ex_br_nzp  = nzp;
    ex_target  = tgt;
    cc         = c;
    cc_pending = p;
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [2:0]  nzp;
    logic [15:0] tgt;
    logic [2:0]  c;
    logic        pend;
    logic        e_stall;
    logic        e_redir;
    logic [15:0] e_pc;
    int          d_res;
    int          d_tkn;
    string       nm;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 4'h0, 3'b010, 16'h3010, 3'b010, 1'b0, 1'b0, 1'b1, 16'h3010, 1, 1, "brz_taken"};
    vecs[1]  = '{1'b1, 4'h0, 3'b100, 16'h3020, 3'b001, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 0, "brn_not_taken"};
    vecs[2]  = '{1'b1, 4'hC, 3'b000, 16'h4000, 3'b001, 1'b1, 1'b0, 1'b1, 16'h4000, 0, 0, "jmp_pending"};
    vecs[3]  = '{1'b1, 4'h0, 3'b000, 16'h3030, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, "nop"};
    vecs[4]  = '{1'b1, 4'h0, 3'b111, 16'h1234, 3'b000, 1'b1, 1'b0, 1'b1, 16'h1234, 0, 0, "bra_pending"};
    vecs[5]  = '{1'b1, 4'h4, 3'b011, 16'h5000, 3'b010, 1'b0, 1'b0, 1'b1, 16'h5000, 0, 0, "jsr"};
    vecs[6]  = '{1'b1, 4'hF, 3'b000, 16'h0020, 3'b100, 1'b0, 1'b0, 1'b1, 16'h0020, 0, 0, "trap"};
    vecs[7]  = '{1'b1, 4'h1, 3'b111, 16'h6000, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, "add_ignored"};
    vecs[8]  = '{1'b1, 4'h0, 3'b101, 16'h3040, 3'b100, 1'b0, 1'b0, 1'b1, 16'h3040, 1, 1, "brnp_taken"};
    vecs[9]  = '{1'b1, 4'h0, 3'b011, 16'h3050, 3'b100, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 0, "brzp_not_taken"};
    vecs[10] = '{1'b0, 4'h0, 3'b111, 16'h3060, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, "invalid"};

    reset = 1'b1;
    mem_stall = 1'b0;
    drive(1'b0, 4'h0, 3'b000, 16'h0000, 3'b000, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_pc", 32'(redirect_pc), 32'd0);
    check("rst_flush", 32'({flush_if, flush_id}), 32'd0);
    check_counts("rst");
    check("rst_b_cnt", 32'({b_resolve_count, b_taken_count}), 32'd0);
    reset = 1'b0;

    // Single-instruction vectors from IDLE.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].op, vecs[i].nzp, vecs[i].tgt, vecs[i].c, vecs[i].pend);
      #1;
      check({vecs[i].nm, "_stall"}, 32'(br_stall), 32'(vecs[i].e_stall));
      @(negedge clk);
      ex_valid = 1'b0;
      exp_res += vecs[i].d_res;
      exp_tkn += vecs[i].d_tkn;
      check({vecs[i].nm, "_redir"}, 32'(redirect), 32'(vecs[i].e_redir));
      check({vecs[i].nm, "_flush1"}, 32'({flush_if, flush_id}), vecs[i].e_redir ? 32'd3 : 32'd0);
      check_counts(vecs[i].nm);
      if (vecs[i].e_redir) begin
        check({vecs[i].nm, "_pc"}, 32'(redirect_pc), 32'(vecs[i].e_pc));
        @(negedge clk);
        check({vecs[i].nm, "_redir2"}, 32'(redirect), 32'd0);
        check({vecs[i].nm, "_flush2"}, 32'({flush_if, flush_id}), 32'd3);
        @(negedge clk);
        check({vecs[i].nm, "_flush3"}, 32'({flush_if, flush_id}), 32'd0);
      end
    end

    // BRp waiting three cycles on cc_pending, then taken.
    @(negedge clk);
    drive(1'b1, 4'h0, 3'b001, 16'h3100, 3'b100, 1'b1);
    #1 check("wait_stall0", 32'(br_stall), 32'd1);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("wait_stall", 32'(br_stall), 32'd1);
      check("wait_no_redir", 32'(redirect), 32'd0);
    end
    @(negedge clk);
    cc_pending = 1'b0;
    cc = 3'b001;
    #1;
    check("wait_release", 32'(br_stall), 32'd0);
    check("wait_redir_early", 32'(redirect), 32'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    exp_res++;
    exp_tkn++;
    check("wait_redir", 32'(redirect), 32'd1);
    check("wait_pc", 32'(redirect_pc), 32'h3100);
    check_counts("wait");
    repeat (2) @(negedge clk);

    // BRn waiting one cycle, resolves not taken.
    drive(1'b1, 4'h0, 3'b100, 16'h3110, 3'b100, 1'b1);
    #1 check("wnt_stall", 32'(br_stall), 32'd1);
    @(negedge clk);
    cc_pending = 1'b0;
    cc = 3'b001;
    #1 check("wnt_release", 32'(br_stall), 32'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    exp_res++;
    check("wnt_redir", 32'(redirect), 32'd0);
    check_counts("wnt");

    // mem_stall for 4 cycles while in REDIRECT.
    @(negedge clk);
    drive(1'b1, 4'h0, 3'b010, 16'h3200, 3'b010, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    exp_res++;
    exp_tkn++;
    check("frz_redir0", 32'(redirect), 32'd1);
    mem_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("frz_redir", 32'(redirect), 32'd1);
      check("frz_flush", 32'({flush_if, flush_id}), 32'd3);
      check("frz_pc", 32'(redirect_pc), 32'h3200);
    end
    mem_stall = 1'b0;
    @(negedge clk);
    check("frz_after_redir", 32'(redirect), 32'd0);
    check("frz_after_flush", 32'({flush_if, flush_id}), 32'd3);
    @(negedge clk);
    check("frz_end_flush", 32'({flush_if, flush_id}), 32'd0);
    check_counts("frz");

    // mem_stall in IDLE blocks resolution.
    @(negedge clk);
    mem_stall = 1'b1;
    drive(1'b1, 4'h0, 3'b010, 16'h3300, 3'b010, 1'b0);
    @(negedge clk);
    check("idle_frz_redir", 32'(redirect), 32'd0);
    check_counts("idle_frz");
    ex_valid = 1'b0;
    mem_stall = 1'b0;
    @(negedge clk);
    check("idle_frz_redir2", 32'(redirect), 32'd0);

    // Asynchronous reset in the middle of FLUSH.
    drive(1'b1, 4'h0, 3'b010, 16'h3400, 3'b010, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    check("mid_flush", 32'({flush_if, flush_id}), 32'd3);
    reset = 1'b1;
    #1;
    exp_res = 0;
    exp_tkn = 0;
    check("arst_flush", 32'({flush_if, flush_id}), 32'd0);
    check("arst_redir", 32'(redirect), 32'd0);
    check("arst_pc", 32'(redirect_pc), 32'd0);
    check_counts("arst");
    @(negedge clk);
    reset = 1'b0;

    // Saturation (3-bit counters) and single-cycle flush window.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(1'b1, 4'h0, 3'b010, 16'h3500, 3'b010, 1'b0);
      @(negedge clk);
      ex_valid = 1'b0;
      exp_res++;
      exp_tkn++;
      if (i == 0) begin
        check("b_redir", 32'(b_redirect), 32'd1);
        check("b_flush1", 32'({b_flush_if, b_flush_id}), 32'd3);
      end
      @(negedge clk);
      if (i == 0) begin
        check("b_flush2", 32'({b_flush_if, b_flush_id}), 32'd0);
        check("a_flush2", 32'({flush_if, flush_id}), 32'd3);
      end
      @(negedge clk);
    end
    drive(1'b1, 4'h0, 3'b100, 16'h3600, 3'b010, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    exp_res++;
    check("b_sat_res", 32'(b_resolve_count), 32'd7);
    check("b_sat_tkn", 32'(b_taken_count), 32'd7);
    check_counts("sat_main");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_branch_resolve.md
Name: ex_branch_resolve

Overview:
- Consumer side of the condition-code path: reads the architected nzp from the CC tracker, together with the EX-stage control-flow instruction.
- Decides whether the branch is taken and stalls EX while a pending MEM-stage result will still update CC.
- Issues a registered PC redirect, then flushes the younger IF/ID instructions for a fixed number of cycles.
- Keeps saturating counters of resolved and taken conditional branches for performance debug.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_if/flush_id stay asserted after a redirect (1..7).
- CNT_WIDTH, 16, width of the resolve/taken counters.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ex_valid  input  1  EX stage holds a valid instruction.
- ex_opcode  input  4  lc3b_opcode of the EX instruction.
- ex_br_nzp  input  3  nzp mask field (IR[11:9]) of the EX instruction.
- ex_target  input  16  computed target PC of the EX instruction.
- cc  input  3  current architected nzp from the CC tracker.
- cc_pending  input  1  an older instruction in MEM will write CC on the next edge.
- mem_stall  input  1  global memory stall; freezes this block.
- br_stall  output  1  hold the EX stage (combinational).
- redirect  output  1  one-cycle (while not frozen) PC redirect strobe, registered.
- redirect_pc  output  16  target for the redirect, registered; valid while redirect=1.
- flush_if  output  1  squash the IF instruction.
- flush_id  output  1  squash the ID instruction.
- resolve_count  output  CNT_WIDTH  number of conditional branches resolved.
- taken_count  output  CNT_WIDTH  number of conditional branches taken.

Behaviour:
- Reset (asynchronous, any time, including mid-WAIT_CC or mid-FLUSH):
  - state=IDLE; redirect=0, redirect_pc=0, flush_if/flush_id=0, both counters=0.
  - Latched instruction fields are cleared.
- Classification, evaluated when ex_valid=1:
  - Conditional: op_br with nzp not 000 and not 111.
  - Unconditional: op_br with nzp=111, op_jmp, op_jsr, op_trap. Always taken; never waits on CC.
  - NOP: op_br with nzp=000. Never taken; no counting.
  - All other opcodes are ignored.
- taken = |(nzp & cc), evaluated against cc in the resolving cycle.
- FSM states: IDLE, WAIT_CC, REDIRECT, FLUSH.
- IDLE:
  - Conditional with cc_pending=1: latch opcode/nzp/target, go to WAIT_CC, br_stall=1 in this same cycle.
  - Conditional with cc_pending=0: resolve now and increment resolve_count.
    - If taken: increment taken_count, load redirect_pc=ex_target, go to REDIRECT.
    - If not taken: stay in IDLE.
  - Unconditional: load redirect_pc=ex_target, go to REDIRECT. Counters unchanged.
- WAIT_CC:
  - br_stall=1.
  - While cc_pending=1, hold the state.
  - On the first cycle with cc_pending=0, resolve using the latched nzp and the current cc, with the same counter and target rules as IDLE. Then go to REDIRECT (taken) or IDLE (not taken).
- REDIRECT:
  - redirect=1 and flush_if=flush_id=1 for exactly one unfrozen cycle.
  - Next state is FLUSH, with an internal counter loaded to FLUSH_CYCLES-1.
  - With FLUSH_CYCLES=1, go straight to IDLE.
- FLUSH:
  - flush_if=flush_id=1 and redirect=0.
  - ex_valid is ignored because the EX instruction is a squashed younger one.
  - The counter decrements each cycle; at 0, go to IDLE.
- Latency:
  - Resolve to redirect high: 1 cycle.
  - redirect high plus flush window: FLUSH_CYCLES cycles total.
  - Taken branch with no CC wait: 1+FLUSH_CYCLES cycles from EX entry back to IDLE.
- mem_stall=1 freezes everything:
  - State, latched fields, flush counter, counters and registered outputs all hold.
  - No new resolution occurs.
  - br_stall keeps its current value.
- Counters saturate at all-ones; they never wrap.
- Simultaneous events:
  - cc_pending=1 together with an unconditional branch: no wait.
  - reset dominates mem_stall.

Test Plan:
- BRz, nzp=010, cc=010, cc_pending=0, target 0x3010 -> next cycle redirect=1 with redirect_pc=0x3010; flush held for 2 cycles total; resolve_count=1, taken_count=1.
- BRn, nzp=100, cc=001 -> no redirect and no flush; resolve_count increments, taken_count unchanged.
- BRp with cc_pending=1 for 3 cycles, cc becomes 001 -> br_stall=1 for 3 cycles, then resolve; redirect is 1 cycle after cc_pending falls.
- JMP target 0x4000 with cc_pending=1 -> no stall; redirect_pc=0x4000 next cycle; counters unchanged. NOP (nzp=000) -> no action.
- mem_stall=1 for 4 cycles during REDIRECT -> redirect and flush held for those cycles; the flush window resumes afterwards.
- Preload counters near 0xFFFF via 65535+ taken branches (or force) -> counters saturate at 0xFFFF. Reset asserted mid-FLUSH -> all outputs 0 immediately, without waiting for a clock edge.
